// File: rtl/seqdec_pkg.sv
// rtl/seqdec_pkg.sv - shared types and constants for the serial pattern detector
package seqdec_pkg;

  localparam int SEQ_W = 8;
  localparam logic [SEQ_W-1:0] DEFAULT_PATTERN = 8'h97;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/seqdec_pat.sv
// rtl/seqdec_pat.sv - bit history, fill tracking, match pulse and saturating match count
module seqdec_pat
  import seqdec_pkg::*;
#(
  parameter logic [SEQ_W-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int               CNT_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic             Match,
  output logic [CNT_W-1:0] MatchCnt
);

  logic [SEQ_W-1:0] hist, hist_next;
  logic [3:0]       fill, fill_next;
  logic             hit;

  // Fill gate keeps an all-zero reset history from matching a zero pattern.
  always_comb begin
    hist_next = {hist[SEQ_W-2:0], bit_in};
    fill_next = (fill == 4'd8) ? 4'd8 : fill + 4'd1;
    hit       = en && (fill_next == 4'd8) && (hist_next == PATTERN);
  end

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      hist     <= '0;
      fill     <= '0;
      Match    <= 1'b0;
      MatchCnt <= '0;
    end else begin
      Match <= hit;
      if (en) begin
        hist <= hist_next;
        fill <= fill_next;
      end
      if (hit && (MatchCnt != {CNT_W{1'b1}}))
        MatchCnt <= MatchCnt + 1'b1;
    end
  end

endmodule

// File: rtl/seqdec_stream_ctrl.sv
// rtl/seqdec_stream_ctrl.sv - byte handshake, MSB-first serializer and detector sequencing
module seqdec_stream_ctrl
  import seqdec_pkg::*;
#(
  parameter logic [SEQ_W-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int               CNT_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic [7:0]       InByte,
  input  logic             InValid,
  output logic             InReady,
  output logic             SerBit,
  output logic             Busy,
  output logic             Match,
  output logic [CNT_W-1:0] MatchCnt
);

  state_t     state, state_next;
  logic [7:0] sreg;
  logic [2:0] bitcnt;
  logic       in_ready, accept, shift_en;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Last bit of a byte overlaps the next accept, so streaming has no bubble.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~Clear;
        if (InValid && in_ready) state_next = SHIFT;
      end
      SHIFT: begin
        in_ready = (bitcnt == 3'd7) && !Clear;
        if ((bitcnt == 3'd7) && !(InValid && in_ready)) state_next = IDLE;
      end
    endcase
    if (Clear) state_next = IDLE;
  end

  assign accept   = InValid && in_ready;
  assign Busy     = (state == SHIFT);
  assign SerBit   = Busy && sreg[7];
  assign shift_en = Busy && !Clear;
  assign InReady  = in_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sreg   <= '0;
      bitcnt <= '0;
    end else if (Clear) begin
      bitcnt <= '0;
    end else if (accept) begin
      sreg   <= InByte;
      bitcnt <= '0;
    end else if (Busy) begin
      sreg   <= {sreg[6:0], 1'b0};
      bitcnt <= bitcnt + 3'd1;
    end
  end

  seqdec_pat #(
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_pat (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (Clear),
    .en       (shift_en),
    .bit_in   (SerBit),
    .Match    (Match),
    .MatchCnt (MatchCnt)
  );

endmodule

// File: tb/tb_seqdec_stream_ctrl.sv
// tb/tb_seqdec_stream_ctrl.sv - directed bench for seqdec_stream_ctrl (default, zero-pattern and 2-bit counter builds)
module tb_seqdec_stream_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Clear, InValid;
  logic [7:0] InByte;

  logic       rdy_a, ser_a, busy_a, match_a;
  logic [7:0] cnt_a;
  logic       rdy_z, ser_z, busy_z, match_z;
  logic [7:0] cnt_z;
  logic       rdy_c, ser_c, busy_c, match_c;
  logic [1:0] cnt_c;

  int tests = 0;
  int fails = 0;
  int seen;

  always #5 Clk = ~Clk;

  seqdec_stream_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .InByte(InByte), .InValid(InValid),
    .InReady(rdy_a), .SerBit(ser_a), .Busy(busy_a), .Match(match_a), .MatchCnt(cnt_a)
  );

  seqdec_stream_ctrl #(.PATTERN(8'h00)) dut_z (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .InByte(InByte), .InValid(InValid),
    .InReady(rdy_z), .SerBit(ser_z), .Busy(busy_z), .Match(match_z), .MatchCnt(cnt_z)
  );

  seqdec_stream_ctrl #(.CNT_W(2)) dut_c (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .InByte(InByte), .InValid(InValid),
    .InReady(rdy_c), .SerBit(ser_c), .Busy(busy_c), .Match(match_c), .MatchCnt(cnt_c)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Clear = 1'b0; InValid = 1'b0; InByte = 8'h00;
    step();
    Reset = 1'b0;
  endtask

  // Presents one byte in IDLE; returns just after its accept edge E0.
  task automatic send(input logic [7:0] b);
    InByte = b; InValid = 1'b1;
    step();
    InValid = 1'b0;
  endtask

  initial begin
    // Reset values
    Reset = 1'b1; Clear = 1'b0; InValid = 1'b0; InByte = 8'h00;
    step(); step();
    chk("rst_ready", rdy_a, 1);
    chk("rst_serbit", ser_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_match", match_a, 0);
    chk("rst_cnt", cnt_a, 0);
    Reset = 1'b0;

    // Single byte 8'h97: match only after E8
    send(8'h97);
    chk("t1_busy_e0", busy_a, 1);
    chk("t1_ser_e0", ser_a, 1);
    chk("t1_ready_e0", rdy_a, 0);
    seen = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (match_a) seen++;
    end
    chk("t1_nomatch_e1_e7", seen, 0);
    chk("t1_ready_e7", rdy_a, 1);
    step();
    chk("t1_match_e8", match_a, 1);
    chk("t1_cnt_e8", cnt_a, 1);
    chk("t1_busy_e8", busy_a, 0);
    chk("t1_ready_e8", rdy_a, 1);
    step();
    chk("t1_match_e9", match_a, 0);
    chk("t1_cnt_e9", cnt_a, 1);

    // Back-to-back 8'h09, 8'h7F: match only after E12
    do_reset();
    InByte = 8'h09; InValid = 1'b1;
    step();
    InByte = 8'h7F;
    for (int k = 1; k <= 7; k++) step();
    chk("t2_ready_e7", rdy_a, 1);
    step();
    InValid = 1'b0;
    chk("t2_busy_e8", busy_a, 1);
    chk("t2_ser_e8", ser_a, 0);
    chk("t2_ready_e8", rdy_a, 0);
    for (int e = 9; e <= 16; e++) begin
      step();
      chk($sformatf("t2_match_e%0d", e), match_a, (e == 12) ? 1 : 0);
    end
    chk("t2_cnt", cnt_a, 1);
    chk("t2_busy_e16", busy_a, 0);

    // Separated bytes with no occurrence of the pattern
    do_reset();
    seen = 0;
    foreach (InByte[i]) begin end
    for (int n = 0; n < 4; n++) begin
      case (n)
        0: send(8'h28);
        1: send(8'h85);
        2: send(8'h42);
        default: send(8'h53);
      endcase
      for (int k = 0; k < 10; k++) begin
        step();
        if (match_a) seen++;
      end
    end
    chk("t3_nomatch", seen, 0);
    chk("t3_cnt", cnt_a, 0);

    // History holds across an idle gap: 8'h09, gap, 8'h7F matches at its E4
    do_reset();
    send(8'h09);
    for (int k = 0; k < 10; k++) step();
    send(8'h7F);
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("t3b_match_e%0d", e), match_a, (e == 4) ? 1 : 0);
    end
    chk("t3b_cnt", cnt_a, 1);

    // Zero pattern: fill gate, then 8 consecutive pulses on the second byte
    do_reset();
    InByte = 8'h00; InValid = 1'b1;
    step();
    seen = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (match_z) seen++;
    end
    chk("t4_nomatch_fill", seen, 0);
    step();
    InValid = 1'b0;
    chk("t4_match_e8", match_z, 1);
    chk("t4_cnt_e8", cnt_z, 1);
    seen = 0;
    for (int e = 9; e <= 16; e++) begin
      step();
      if (match_z) seen++;
    end
    chk("t4_pulses", seen, 8);
    chk("t4_cnt", cnt_z, 9);
    step();
    chk("t4_match_e17", match_z, 0);

    // Clear at E4 of 8'h97
    do_reset();
    send(8'h97);
    for (int k = 1; k <= 3; k++) step();
    Clear = 1'b1; InValid = 1'b1; InByte = 8'h97;
    #1;
    chk("t5_ready_clear", rdy_a, 0);
    step();
    chk("t5_ready_held", rdy_a, 0);
    Clear = 1'b0; InValid = 1'b0;
    #1;
    chk("t5_busy", busy_a, 0);
    chk("t5_ready", rdy_a, 1);
    chk("t5_cnt0", cnt_a, 0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (match_a || busy_a) seen++;
    end
    chk("t5_quiet", seen, 0);
    chk("t5_cnt", cnt_a, 0);

    // 2-bit counter saturates at 3
    do_reset();
    for (int n = 0; n < 5; n++) begin
      send(8'h97);
      for (int k = 1; k <= 8; k++) step();
      chk($sformatf("t6_cnt_byte%0d", n), cnt_c, (n < 3) ? n + 1 : 3);
    end

    // Reset mid-byte
    send(8'h97);
    for (int k = 1; k <= 3; k++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("t6_rst_ready", rdy_c, 1);
    chk("t6_rst_serbit", ser_c, 0);
    chk("t6_rst_busy", busy_c, 0);
    chk("t6_rst_match", match_c, 0);
    chk("t6_rst_cnt", cnt_c, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
